// File: rtl/t3_2_csa_stage.sv
// t3_2_csa_stage: compresses the six 48-bit partial-product rows from the T3_1
// register into one sum/carry pair through three 3:2 CSA levels. The result and
// its sidebands are registered behind a valid/ready handshake.
// Optional skid register: define T3_2_SKID_EN to get two-entry storage with a
// registered in_ready. Leave it undefined for a single main register with a
// combinational in_ready.
// `PERIOD is the team register-assignment delay; it defaults to empty.

`ifndef PERIOD
`define PERIOD
`endif

module t3_2_csa_stage (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [287:0] in_level,
  input  logic [5:0]   in_sign,
  input  logic [2:0]   in_cont,
  input  logic [11:0]  in_d,
  input  logic [11:0]  in_E,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [47:0]  out_sum,
  output logic [47:0]  out_carry,
  output logic [5:0]   out_sign,
  output logic [2:0]   out_cont,
  output logic [11:0]  out_d,
  output logic [11:0]  out_E
);

  localparam int W  = 48;
  localparam int N  = 6;
  localparam int LW = W * N;

  // Full-adder sum bit of each column.
  function automatic logic [W-1:0] fa_sum(input logic [W-1:0] a,
                                          input logic [W-1:0] b,
                                          input logic [W-1:0] c);
    return a ^ b ^ c;
  endfunction

  // Majority of each column, moved up one weight; the top carry falls off.
  function automatic logic [W-1:0] fa_carry(input logic [W-1:0] a,
                                            input logic [W-1:0] b,
                                            input logic [W-1:0] c);
    logic [W-1:0] maj;
    maj = (a & b) | (a & c) | (b & c);
    return {maj[W-2:0], 1'b0};
  endfunction

  logic          in_fire;
  logic          main_free;
  logic          src_valid;
  logic [LW-1:0] src_level;
  logic [5:0]    src_sign;
  logic [2:0]    src_cont;
  logic [11:0]   src_d;
  logic [11:0]   src_E;

  logic [W-1:0]  row [N];
  logic [W-1:0]  s0, c0, s1, c1, s2, c2;
  logic [W-1:0]  csa_sum, csa_carry;

  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  out_sum_q, out_sum_d;
  logic [W-1:0]  out_carry_q, out_carry_d;
  logic [5:0]    out_sign_q, out_sign_d;
  logic [2:0]    out_cont_q, out_cont_d;
  logic [11:0]   out_d_q, out_d_d;
  logic [11:0]   out_E_q, out_E_d;

  assign in_fire   = in_valid && in_ready;
  assign main_free = !out_valid_q || out_ready;

`ifdef T3_2_SKID_EN
  logic          skid_valid_q, skid_valid_d;
  logic [LW-1:0] skid_level_q, skid_level_d;
  logic [5:0]    skid_sign_q, skid_sign_d;
  logic [2:0]    skid_cont_q, skid_cont_d;
  logic [11:0]   skid_d_q, skid_d_d;
  logic [11:0]   skid_E_q, skid_E_d;
  logic          in_ready_q, in_ready_d;

  assign in_ready = in_ready_q;

  // A parked beat is older than anything at the input, so it loads main first.
  always_comb begin
    src_valid = skid_valid_q || in_fire;
    if (skid_valid_q) begin
      src_level = skid_level_q;
      src_sign  = skid_sign_q;
      src_cont  = skid_cont_q;
      src_d     = skid_d_q;
      src_E     = skid_E_q;
    end else begin
      src_level = in_level;
      src_sign  = in_sign;
      src_cont  = in_cont;
      src_d     = in_d;
      src_E     = in_E;
    end
  end

  // Skid empties when main can take it; fills when a beat arrives behind a stalled main.
  always_comb begin
    skid_valid_d = skid_valid_q;
    skid_level_d = skid_level_q;
    skid_sign_d  = skid_sign_q;
    skid_cont_d  = skid_cont_q;
    skid_d_d     = skid_d_q;
    skid_E_d     = skid_E_q;
    if (main_free) begin
      if (skid_valid_q) begin
        skid_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      skid_valid_d = 1'b1;
      skid_level_d = in_level;
      skid_sign_d  = in_sign;
      skid_cont_d  = in_cont;
      skid_d_d     = in_d;
      skid_E_d     = in_E;
    end
    in_ready_d = !skid_valid_d;
  end

  // Skid storage and the registered ready that mirrors its emptiness.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_valid_q <= `PERIOD 1'b0;
      skid_level_q <= `PERIOD '0;
      skid_sign_q  <= `PERIOD '0;
      skid_cont_q  <= `PERIOD '0;
      skid_d_q     <= `PERIOD '0;
      skid_E_q     <= `PERIOD '0;
      in_ready_q   <= `PERIOD 1'b1;
    end else begin
      skid_valid_q <= `PERIOD skid_valid_d;
      skid_level_q <= `PERIOD skid_level_d;
      skid_sign_q  <= `PERIOD skid_sign_d;
      skid_cont_q  <= `PERIOD skid_cont_d;
      skid_d_q     <= `PERIOD skid_d_d;
      skid_E_q     <= `PERIOD skid_E_d;
      in_ready_q   <= `PERIOD in_ready_d;
    end
  end
`else
  assign in_ready = main_free;

  // Without skid the input is the only source for main.
  always_comb begin
    src_valid = in_fire;
    src_level = in_level;
    src_sign  = in_sign;
    src_cont  = in_cont;
    src_d     = in_d;
    src_E     = in_E;
  end
`endif

  // Split the flattened level into its six rows.
  always_comb begin
    for (int k = 0; k < N; k++) begin
      row[k] = src_level[k*W +: W];
    end
  end

  // Three CSA levels: 6 rows -> 4 -> 3 -> sum/carry pair.
  always_comb begin
    s0        = fa_sum  (row[0], row[1], row[2]);
    c0        = fa_carry(row[0], row[1], row[2]);
    s1        = fa_sum  (row[3], row[4], row[5]);
    c1        = fa_carry(row[3], row[4], row[5]);
    s2        = fa_sum  (s0, c0, s1);
    c2        = fa_carry(s0, c0, s1);
    csa_sum   = fa_sum  (s2, c2, c1);
    csa_carry = fa_carry(s2, c2, c1);
  end

  // Main loads when empty or draining; otherwise it holds its beat steady.
  always_comb begin
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_carry_d = out_carry_q;
    out_sign_d  = out_sign_q;
    out_cont_d  = out_cont_q;
    out_d_d     = out_d_q;
    out_E_d     = out_E_q;
    if (main_free) begin
      out_valid_d = src_valid;
      if (src_valid) begin
        out_sum_d   = csa_sum;
        out_carry_d = csa_carry;
        out_sign_d  = src_sign;
        out_cont_d  = src_cont;
        out_d_d     = src_d;
        out_E_d     = src_E;
      end
    end
  end

  // Main register, which drives the outputs directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= `PERIOD 1'b0;
      out_sum_q   <= `PERIOD '0;
      out_carry_q <= `PERIOD '0;
      out_sign_q  <= `PERIOD '0;
      out_cont_q  <= `PERIOD '0;
      out_d_q     <= `PERIOD '0;
      out_E_q     <= `PERIOD '0;
    end else begin
      out_valid_q <= `PERIOD out_valid_d;
      out_sum_q   <= `PERIOD out_sum_d;
      out_carry_q <= `PERIOD out_carry_d;
      out_sign_q  <= `PERIOD out_sign_d;
      out_cont_q  <= `PERIOD out_cont_d;
      out_d_q     <= `PERIOD out_d_d;
      out_E_q     <= `PERIOD out_E_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_carry = out_carry_q;
  assign out_sign  = out_sign_q;
  assign out_cont  = out_cont_q;
  assign out_d     = out_d_q;
  assign out_E     = out_E_q;

endmodule

// File: tb/tb_t3_2_csa_stage.sv
// tb_t3_2_csa_stage: directed and randomized checks of t3_2_csa_stage against
// a queue-based reference that sums the six rows arithmetically.
// Works for both builds (T3_2_SKID_EN defined or not).

module tb_t3_2_csa_stage;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [287:0] in_level;
  logic [5:0]   in_sign;
  logic [2:0]   in_cont;
  logic [11:0]  in_d;
  logic [11:0]  in_E;
  logic         out_valid;
  logic         out_ready;
  logic [47:0]  out_sum;
  logic [47:0]  out_carry;
  logic [5:0]   out_sign;
  logic [2:0]   out_cont;
  logic [11:0]  out_d;
  logic [11:0]  out_E;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [47:0] sum;
    logic [5:0]  sign;
    logic [2:0]  cont;
    logic [11:0] d;
    logic [11:0] e;
  } beat_t;

  beat_t exp_q[$];
  int    accepted_n = 0;
  int    delivered_n = 0;

  logic        prev_stall = 1'b0;
  logic [95:0] prev_data = '0;
  logic [32:0] prev_side = '0;
  beat_t       mon_exp;
  beat_t       mon_new;
  logic [47:0] mon_tot;

  t3_2_csa_stage dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_level  (in_level),
    .in_sign   (in_sign),
    .in_cont   (in_cont),
    .in_d      (in_d),
    .in_E      (in_E),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_carry (out_carry),
    .out_sign  (out_sign),
    .out_cont  (out_cont),
    .out_d     (out_d),
    .out_E     (out_E)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Reference: the six rows added as plain integers, wrapped to 48 bits.
  function automatic logic [47:0] refSum(input logic [287:0] lvl);
    logic [47:0] acc;
    acc = '0;
    for (int k = 0; k < 6; k++) acc = acc + lvl[k*48 +: 48];
    return acc;
  endfunction

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until accepted (bounded).
  task automatic applyStimulus(input logic [287:0] lvl, input logic [5:0] sg,
                               input logic [2:0] ct, input logic [11:0] dd,
                               input logic [11:0] ee);
    bit took;
    took = 1'b0;
    in_level = lvl;
    in_sign  = sg;
    in_cont  = ct;
    in_d     = dd;
    in_E     = ee;
    in_valid = 1'b1;
    for (int n = 0; n < 50 && !took; n++) begin
      @(negedge clk);
      took = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    checkOutput("accept_timeout", 128'(took), 128'(1));
  endtask

  // Scoreboard: record accepted beats, check delivered beats in order, and
  // check that a stalled output holds still.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall) begin
        checkOutput("hold_data", 128'({out_sum, out_carry}), 128'(prev_data));
        checkOutput("hold_side", 128'({out_valid, out_sign, out_cont, out_d, out_E}),
                    128'({1'b1, prev_side}));
      end
      if (out_valid && out_ready) begin
        checkOutput("queue_nonempty", 128'(exp_q.size() != 0), 128'(1));
        checkOutput("carry_lsb", 128'(out_carry[0]), 128'(0));
        if (exp_q.size() != 0) begin
          mon_exp = exp_q.pop_front();
          mon_tot = out_sum + out_carry;
          checkOutput("sum_carry", 128'(mon_tot), 128'(mon_exp.sum));
          checkOutput("sidebands", 128'({out_sign, out_cont, out_d, out_E}),
                      128'({mon_exp.sign, mon_exp.cont, mon_exp.d, mon_exp.e}));
        end
        delivered_n <= delivered_n + 1;
      end
      if (in_valid && in_ready) begin
        mon_new.sum  = refSum(in_level);
        mon_new.sign = in_sign;
        mon_new.cont = in_cont;
        mon_new.d    = in_d;
        mon_new.e    = in_E;
        exp_q.push_back(mon_new);
        accepted_n <= accepted_n + 1;
      end
      prev_stall <= out_valid && !out_ready;
      prev_data  <= {out_sum, out_carry};
      prev_side  <= {out_sign, out_cont, out_d, out_E};
    end
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0]  rdy_seq;
    logic [3:0]  exp_seq;
    int          exp_acc;
    int          idx;
    bit          took;
    int          sent;
    int          cycles;
    int          a0;
    int          d0;
    logic [47:0] tot;

`ifdef T3_2_SKID_EN
    exp_acc = 2;
    exp_seq = 4'b0011;
`else
    exp_acc = 1;
    exp_seq = 4'b0001;
`endif

    rst       = 1'b0;
    in_valid  = 1'b0;
    in_level  = '0;
    in_sign   = '0;
    in_cont   = '0;
    in_d      = '0;
    in_E      = '0;
    out_ready = 1'b1;
    #1 rst = 1'b1;
    #1;
    checkOutput("rst_out_valid", 128'(out_valid), 128'(0));
    checkOutput("rst_data", 128'({out_sum, out_carry}), 128'(0));
    checkOutput("rst_side", 128'({out_sign, out_cont, out_d, out_E}), 128'(0));
    checkOutput("rst_in_ready", 128'(in_ready), 128'(1));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Six rows of one: total 6, visible one cycle after acceptance.
    $display("[TB] six rows of 1");
    applyStimulus({6{48'h1}}, 6'd0, 3'd0, 12'd0, 12'd0);
    tot = out_sum + out_carry;
    checkOutput("ones_valid", 128'(out_valid), 128'(1));
    checkOutput("ones_sum", 128'(tot), 128'(6));

    // All-ones rows wrap to -6; sidebands ride along unchanged.
    $display("[TB] all-ones rows with sidebands");
    applyStimulus({6{48'hFFFF_FFFF_FFFF}}, 6'b101010, 3'd5, 12'd17, 12'h3FF);
    tot = out_sum + out_carry;
    checkOutput("max_valid", 128'(out_valid), 128'(1));
    checkOutput("max_sum", 128'(tot), 128'(48'hFFFF_FFFF_FFFA));
    checkOutput("max_sign", 128'(out_sign), 128'(6'b101010));
    checkOutput("max_cont", 128'(out_cont), 128'(3'd5));
    checkOutput("max_d", 128'(out_d), 128'(12'd17));
    checkOutput("max_E", 128'(out_E), 128'(12'h3FF));

    // Back-to-back stream: every cycle accepts and every next cycle shows it.
    $display("[TB] back-to-back stream of 8");
    for (int i = 0; i < 8; i++) begin
      in_level = {240'd0, 48'(i)};
      in_sign  = 6'(i);
      in_cont  = 3'(i);
      in_d     = 12'(i);
      in_E     = 12'(i);
      in_valid = 1'b1;
      stepCycle();
      tot = out_sum + out_carry;
      checkOutput("stream_valid", 128'(out_valid), 128'(1));
      checkOutput("stream_sum", 128'(tot), 128'(i));
    end
    in_valid = 1'b0;
    repeat (2) stepCycle();
    checkOutput("stream_drained", 128'(out_valid), 128'(0));

    // Stall for 4 cycles with a continuously offered input.
    $display("[TB] stall with back-pressure");
    out_ready = 1'b0;
    idx = 0;
    rdy_seq = '0;
    for (int c = 0; c < 4; c++) begin
      in_level = {240'd0, 48'(100 + idx)};
      in_sign  = 6'(idx);
      in_valid = 1'b1;
      @(negedge clk);
      took = in_ready;
      rdy_seq[c] = in_ready;
      @(posedge clk);
      #1;
      if (took) idx++;
    end
    in_valid = 1'b0;
    checkOutput("stall_accepts", 128'(idx), 128'(exp_acc));
    checkOutput("stall_ready_seq", 128'(rdy_seq), 128'(exp_seq));
    out_ready = 1'b1;
    for (int n = 0; n < 10 && exp_q.size() != 0; n++) stepCycle();
    stepCycle();
    checkOutput("stall_drained", 128'(exp_q.size()), 128'(0));
    checkOutput("stall_out_valid", 128'(out_valid), 128'(0));

    // Fill storage, then reset asynchronously mid-cycle.
    $display("[TB] reset with storage full");
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 3; c++) begin
      in_level = {240'd0, 48'(200 + idx)};
      in_E     = 12'(idx + 1);
      in_valid = 1'b1;
      @(negedge clk);
      took = in_ready;
      @(posedge clk);
      #1;
      if (took) idx++;
    end
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    checkOutput("midrst_out_valid", 128'(out_valid), 128'(0));
    checkOutput("midrst_data", 128'({out_sum, out_carry}), 128'(0));
    checkOutput("midrst_side", 128'({out_sign, out_cont, out_d, out_E}), 128'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    checkOutput("postrst_in_ready", 128'(in_ready), 128'(1));
    out_ready = 1'b1;
    applyStimulus({48'd5, 192'd0, 48'd300}, 6'b010101, 3'd2, 12'd9, 12'h123);
    tot = out_sum + out_carry;
    checkOutput("postrst_valid", 128'(out_valid), 128'(1));
    checkOutput("postrst_sum", 128'(tot), 128'(305));
    checkOutput("postrst_E", 128'(out_E), 128'(12'h123));
    stepCycle();

    // Randomized traffic with random back-pressure.
    $display("[TB] random traffic");
    a0 = accepted_n;
    d0 = delivered_n;
    sent = 0;
    cycles = 0;
    while (sent < 10000 && cycles < 40000) begin
      if (!in_valid && $urandom_range(0, 3) != 0) begin
        for (int k = 0; k < 6; k++) in_level[k*48 +: 48] = {$urandom, $urandom};
        in_sign  = 6'($urandom);
        in_cont  = 3'($urandom);
        in_d     = 12'($urandom);
        in_E     = 12'($urandom);
        in_valid = 1'b1;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      took = in_valid && in_ready;
      @(posedge clk);
      #1;
      cycles++;
      if (took) begin
        sent++;
        in_valid = 1'b0;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 20 && exp_q.size() != 0; n++) stepCycle();
    stepCycle();
    checkOutput("rand_sent", 128'(sent), 128'(10000));
    checkOutput("rand_accepted", 128'(accepted_n - a0), 128'(sent));
    checkOutput("rand_delivered", 128'(delivered_n - d0), 128'(sent));
    checkOutput("rand_queue_empty", 128'(exp_q.size()), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/t3_2_csa_stage.md
# t3_2_csa_stage

Consumer stage directly downstream of the T3_1 pipeline register in the MAF datapath. Accepts the registered 288-bit partial-product level (six 48-bit rows) with its sign, control, shift-distance and exponent sidebands. Compresses the six rows to one sum/carry pair through three 3:2 CSA levels and registers the result with the sidebands aligned to it. Adds a valid/ready handshake so back-pressure from the final adder stage stalls the multiplier tree without losing or reordering beats.

## Interface
- Parameters: none; widths are fixed by the datapath. Row width is 48, row count is 6.
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  input beat present
- in_ready  output  1  stage can accept a beat this cycle
- in_level  input  288  row k = in_level[48k+47:48k], k=0..5
- in_sign  input  6  {S_C_H, S_B_H, S_A_H, S_C, S_B, S_A} sign flags
- in_cont  input  3  operation control code
- in_d  input  12  alignment shift distance
- in_E  input  12  exponent
- out_valid  output  1  output beat present
- out_ready  input  1  downstream accepts the beat
- out_sum  output  48  CSA sum vector
- out_carry  output  48  CSA carry vector, already shifted left by 1
- out_sign  output  6  sign flags aligned to out_sum
- out_cont  output  3  aligned control code
- out_d  output  12  aligned shift distance
- out_E  output  12  aligned exponent

## Operation
- Level A: rows 0,1,2 produce s0/c0; rows 3,4,5 produce s1/c1.
- Level B: s0, c0, s1 produce s2/c2.
- Level C: s2, c2, c1 produce out_sum/out_carry.
- Each carry is (majority << 1), truncated to 48 bits. Invariant: out_sum + out_carry ≡ sum of the six rows mod 2^48.
- Sidebands pass through unmodified and move with their beat.
- An input transfer occurs on in_valid && in_ready. An output transfer occurs on out_valid && out_ready.
- Storage is a main register, which drives the outputs, plus an optional skid register (see Configuration).
- Main register loads when it is empty or its beat is leaving this cycle. The source is the skid register if that is full, otherwise the input.
- With skid enabled, an accepted beat that cannot enter main goes to skid.
- Beats leave in acceptance order. No beat is dropped or duplicated.
- Reset values: out_valid=0; out_sum, out_carry, out_sign, out_cont, out_d, out_E all 0; skid empty; in_ready=1.
- Inputs are ignored while rst is high.
- Reset mid-operation: all held beats are discarded immediately (asynchronous). The first beat accepted after release is the first beat output.
- All register assignments use the team delay macro `PERIOD.

## Timing
- Latency: a beat accepted at edge N appears on the outputs after edge N, with out_valid=1 in cycle N+1, when main is empty or draining.
- Throughput: one beat per cycle while out_ready stays 1.
- out_valid and the out_* data are held stable while out_valid && !out_ready.
- in_valid with in_ready=0: no transfer. The upstream holds the beat.
- Simultaneous output transfer and input transfer on the same edge: main takes the next beat (skid first, if full). No bubble is inserted.
- The CSA path is combinational from the load source to main. It is three full-adder levels deep.

## Configuration
- Macro: T3_2_SKID_EN.
- When defined:
  - Two-entry storage (main plus skid).
  - in_ready is a register equal to !skid_full. It has no combinational path from out_ready.
  - A beat arriving while main is stalled goes to skid, and in_ready drops on the next cycle.
  - When out_ready returns, skid moves to main and in_ready rises on the following cycle.
- When undefined:
  - Main register only.
  - in_ready = !out_valid || out_ready, combinational.
- Data results and latency are identical in both builds.

## Test plan
- Six rows of 48'h1 with out_ready=1: out_valid=1 one cycle later, and out_sum+out_carry mod 2^48 = 6.
- Six rows of 48'hFFFF_FFFF_FFFF, in_E=12'h3FF, in_d=12'd17, in_sign=6'b101010: sum+carry = 48'hFFFF_FFFF_FFFA, and the sidebands appear unchanged on the same cycle.
- Back-to-back stream of 8 beats with row0 = beat index and other rows 0, out_ready=1: 8 consecutive outputs with sums 0..7 and no bubbles.
- Hold out_ready=0 for 4 cycles while driving in_valid=1:
  - With T3_2_SKID_EN: exactly 2 beats are accepted and in_ready falls 1 cycle after skid fills. After out_ready=1, the outputs come out in order.
  - Without the macro: exactly 1 beat is accepted.
- Assert rst for 1 cycle while both main and skid are full: out_valid=0 and all outputs 0 immediately. After release in_ready=1 and the next accepted beat is the first output.
- Random rows, random in_valid/out_ready, 10k beats: out_sum+out_carry matches a reference sum mod 2^48, in order, with no loss.
